// File: rtl/hornet_irq_pkg.sv
// Shared definitions for the hornet machine-external interrupt controller:
// register offsets (word index, wb_adr_i[3:2]), FSM state encoding, claim ID width.
package hornet_irq_pkg;

    localparam int IRQ_ID_W = 5;

    localparam logic [1:0] IRQ_PENDING = 2'd0;
    localparam logic [1:0] IRQ_ENABLE  = 2'd1;
    localparam logic [1:0] IRQ_EDGE    = 2'd2;
    localparam logic [1:0] IRQ_CLAIM   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        SVC    = 2'd2
    } irq_state_e;

endpackage

// File: rtl/hornet_irq_sync.sv
// Source conditioning for hornet_irq_ctrl: optional 2-flop synchronizer
// (enabled by defining HORNET_IRQ_SYNC_EN) followed by a previous-value flop
// that turns the conditioned level into a one-cycle rising-edge pulse.
module hornet_irq_sync #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] src,
    output logic [N-1:0] level,
    output logic [N-1:0] rise
);

    logic [N-1:0] prev_q;

`ifdef HORNET_IRQ_SYNC_EN
    logic [N-1:0] meta_q;
    logic [N-1:0] sync_q;

    // Two-stage synchronizer so asynchronous request lines settle before use
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= src;
            sync_q <= meta_q;
        end
    end

    assign level = sync_q;
`else
    assign level = src;
`endif

    // Remember last cycle's level so a 0->1 transition can be detected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/hornet_irq_ctrl.sv
// Machine-external interrupt controller with a Wishbone-classic register file.
// Collects N_SRC request lines, arbitrates lowest-index-first, raises meip_o
// and hands the claimed ID to software through the CLAIM register.
// Define HORNET_IRQ_SYNC_EN to insert a 2-flop synchronizer on every source.
module hornet_irq_ctrl #(
    parameter int N_SRC = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [N_SRC-1:0] src_i,
    output logic             meip_o,
    input  logic             irq_ack_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [3:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o
);

    import hornet_irq_pkg::*;

    logic [N_SRC-1:0]    src_level;
    logic [N_SRC-1:0]    src_rise;
    logic [N_SRC-1:0]    pending_q;
    logic [N_SRC-1:0]    enable_q;
    logic [N_SRC-1:0]    edge_q;
    logic [N_SRC-1:0]    req;
    logic [N_SRC-1:0]    w1c_clr;
    logic [N_SRC-1:0]    claim_clr;
    logic [N_SRC-1:0]    pending_d;
    irq_state_e          state_q;
    irq_state_e          state_d;
    logic                active_q;
    logic [IRQ_ID_W-1:0] id_q;
    logic                win_valid;
    logic [IRQ_ID_W-1:0] win_id;
    logic                take_claim;
    logic                drop_claim;
    logic                complete;
    logic                wb_req;
    logic                wb_wr;
    logic                wb_rd;
    logic [1:0]          reg_sel;
    logic [31:0]         rd_data;
    logic                unused_bits;

    // Byte selects and the low address bits are intentionally ignored
    assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i};

    hornet_irq_sync #(.N(N_SRC)) u_sync (
        .clk   (clk_i),
        .rst_n (reset_i),
        .src   (src_i),
        .level (src_level),
        .rise  (src_rise)
    );

    assign wb_req  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wb_wr   = wb_req & wb_we_i;
    assign wb_rd   = wb_req & ~wb_we_i;
    assign reg_sel = wb_adr_i[3:2];
    assign req     = pending_q & enable_q;

    // Fixed-priority arbiter: scan downward so the lowest set index wins
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_valid = 1'b1;
                win_id    = IRQ_ID_W'(i);
            end
        end
    end

    // Next-state and meip_o; the ack only matters in ASSERT, a CLAIM write only in SVC
    always_comb begin
        state_d    = state_q;
        meip_o     = 1'b0;
        take_claim = 1'b0;
        drop_claim = 1'b0;
        complete   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) state_d = ASSERT;
            end
            ASSERT: begin
                meip_o = 1'b1;
                if (irq_ack_i) begin
                    if (win_valid) begin
                        take_claim = 1'b1;
                        state_d    = SVC;
                    end else begin
                        drop_claim = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            SVC: begin
                if (wb_wr && (reg_sel == IRQ_CLAIM)) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Claimed ID and active flag seen by the trap handler
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            active_q <= 1'b0;
            id_q     <= '0;
        end else if (take_claim) begin
            active_q <= 1'b1;
            id_q     <= win_id;
        end else if (drop_claim || complete) begin
            active_q <= 1'b0;
        end
    end

    // Edge bits: clear sources are W1C and the claim; a fresh rise overrides both
    always_comb begin
        w1c_clr   = '0;
        claim_clr = '0;
        if (wb_wr && (reg_sel == IRQ_PENDING)) w1c_clr = wb_dat_i[N_SRC-1:0];
        for (int i = 0; i < N_SRC; i++) begin
            claim_clr[i] = take_claim && edge_q[i] && (win_id == IRQ_ID_W'(i));
        end
        pending_d = (edge_q & ((pending_q & ~(w1c_clr | claim_clr)) | src_rise))
                  | (~edge_q & src_level);
    end

    // Pending, enable and edge-mode registers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pending_q <= '0;
            enable_q  <= '0;
            edge_q    <= '0;
        end else begin
            pending_q <= pending_d;
            if (wb_wr && (reg_sel == IRQ_ENABLE)) enable_q <= wb_dat_i[N_SRC-1:0];
            if (wb_wr && (reg_sel == IRQ_EDGE))   edge_q   <= wb_dat_i[N_SRC-1:0];
        end
    end

    // Read mux; bits at or above N_SRC are zero-extended
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            IRQ_PENDING: rd_data = 32'(pending_q);
            IRQ_ENABLE:  rd_data = 32'(enable_q);
            IRQ_EDGE:    rd_data = 32'(edge_q);
            IRQ_CLAIM:   rd_data = {active_q, 26'b0, id_q};
            default:     rd_data = '0;
        endcase
    end

    // Registered ack and read data; data is forced to zero outside the ack cycle
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= wb_req;
            wb_dat_o <= wb_rd ? rd_data : 32'h0;
        end
    end

endmodule

// File: tb/tb_hornet_irq_ctrl.sv
// Directed self-checking bench for hornet_irq_ctrl with hand-computed expectations.
// Latencies track HORNET_IRQ_SYNC_EN so the bench fits either build.
module tb_hornet_irq_ctrl;

`ifdef HORNET_IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    localparam logic [3:0] A_PENDING = 4'h0;
    localparam logic [3:0] A_ENABLE  = 4'h4;
    localparam logic [3:0] A_EDGE    = 4'h8;
    localparam logic [3:0] A_CLAIM   = 4'hC;

    logic        clk_i;
    logic        reset_i;
    logic [7:0]  src_i;
    logic        meip_o;
    logic        irq_ack_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] rdata;

    hornet_irq_ctrl #(.N_SRC(8)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .src_i     (src_i),
        .meip_o    (meip_o),
        .irq_ack_i (irq_ack_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_we_i   (wb_we_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_i  (wb_sel_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o)
    );

    // Free-running 100 MHz clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Compare one observed value against its expectation and count it
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 ns after the last edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Drive source lines and ack, hold for the given edges, then drop ack
    task automatic applyStimulus(input logic [7:0] src, input logic ack, input int cycles);
        src_i     = src;
        irq_ack_i = ack;
        tick(cycles);
        irq_ack_i = 1'b0;
    endtask

    // One Wishbone write followed by the mandatory idle cycle
    task automatic wbWrite(input logic [3:0] adr, input logic [31:0] dat);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = adr;
        wb_dat_i = dat;
        tick(1);
        checkOutput("wr_ack", {31'b0, wb_ack_o}, 32'h1);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        tick(1);
    endtask

    // One Wishbone read followed by the mandatory idle cycle
    task automatic wbRead(input logic [3:0] adr, output logic [31:0] dat);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = adr;
        tick(1);
        dat = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        tick(1);
    endtask

    initial begin
        reset_i   = 1'b0;
        src_i     = '0;
        irq_ack_i = 1'b0;
        wb_cyc_i  = 1'b0;
        wb_stb_i  = 1'b0;
        wb_we_i   = 1'b0;
        wb_adr_i  = '0;
        wb_dat_i  = '0;
        wb_sel_i  = 4'hF;

        // Reset values
        tick(8);
        checkOutput("rst_meip", {31'b0, meip_o}, 32'h0);
        checkOutput("rst_ack", {31'b0, wb_ack_o}, 32'h0);
        checkOutput("rst_dat", wb_dat_o, 32'h0);
        reset_i = 1'b1;
        tick(1);
        wbRead(A_PENDING, rdata); checkOutput("rst_pending", rdata, 32'h0);
        wbRead(A_ENABLE, rdata);  checkOutput("rst_enable", rdata, 32'h0);
        wbRead(A_EDGE, rdata);    checkOutput("rst_edge", rdata, 32'h0);
        wbRead(A_CLAIM, rdata);   checkOutput("rst_claim", rdata, 32'h0);
        checkOutput("dat_idle", wb_dat_o, 32'h0);

        // Level source 3
        wbWrite(A_ENABLE, 32'h08);
        applyStimulus(8'h08, 1'b0, 1 + SYNC_LAT);
        checkOutput("lvl_meip_early", {31'b0, meip_o}, 32'h0);
        applyStimulus(8'h08, 1'b0, 1);
        checkOutput("lvl_meip_rise", {31'b0, meip_o}, 32'h1);
        applyStimulus(8'h08, 1'b1, 1);
        checkOutput("lvl_meip_ack", {31'b0, meip_o}, 32'h0);
        wbRead(A_CLAIM, rdata);   checkOutput("lvl_claim", rdata, 32'h8000_0003);
        wbWrite(A_CLAIM, 32'h0);
        checkOutput("lvl_reassert", {31'b0, meip_o}, 32'h1);
        applyStimulus(8'h00, 1'b0, 2 + SYNC_LAT);
        applyStimulus(8'h00, 1'b1, 1);
        checkOutput("lvl_noWinner_meip", {31'b0, meip_o}, 32'h0);
        wbRead(A_CLAIM, rdata);   checkOutput("lvl_noWinner_claim", rdata, 32'h0000_0003);

        // Edge priority between sources 1 and 5
        wbWrite(A_EDGE, 32'h22);
        wbWrite(A_ENABLE, 32'h22);
        applyStimulus(8'h22, 1'b0, 1);
        applyStimulus(8'h00, 1'b0, 2 + SYNC_LAT);
        checkOutput("edge_meip", {31'b0, meip_o}, 32'h1);
        applyStimulus(8'h00, 1'b1, 1);
        wbRead(A_CLAIM, rdata);   checkOutput("edge_claim1", rdata, 32'h8000_0001);
        wbRead(A_PENDING, rdata); checkOutput("edge_pending1", rdata, 32'h20);
        wbWrite(A_CLAIM, 32'h0);
        checkOutput("edge_meip2", {31'b0, meip_o}, 32'h1);
        applyStimulus(8'h00, 1'b1, 1);
        wbRead(A_CLAIM, rdata);   checkOutput("edge_claim5", rdata, 32'h8000_0005);
        wbRead(A_PENDING, rdata); checkOutput("edge_pending5", rdata, 32'h0);
        wbWrite(A_CLAIM, 32'h0);
        tick(2);
        checkOutput("edge_meip_done", {31'b0, meip_o}, 32'h0);

        // Masking of level source 2
        wbWrite(A_ENABLE, 32'h0);
        applyStimulus(8'h04, 1'b0, 20);
        checkOutput("mask_meip", {31'b0, meip_o}, 32'h0);
        wbRead(A_PENDING, rdata); checkOutput("mask_pending", rdata, 32'h04);
        wbWrite(A_ENABLE, 32'h04);
        checkOutput("mask_unmask_meip", {31'b0, meip_o}, 32'h1);
        applyStimulus(8'h00, 1'b0, 2 + SYNC_LAT);
        applyStimulus(8'h00, 1'b1, 1);
        checkOutput("mask_clean_meip", {31'b0, meip_o}, 32'h0);
        wbWrite(A_ENABLE, 32'h0);

        // W1C colliding with a new edge on bit 0
        wbWrite(A_EDGE, 32'h01);
        applyStimulus(8'h01, 1'b0, 1);
        applyStimulus(8'h00, 1'b0, 2 + SYNC_LAT);
        wbRead(A_PENDING, rdata); checkOutput("w1c_pre", rdata, 32'h01);
        applyStimulus(8'h01, 1'b0, SYNC_LAT);
        wbWrite(A_PENDING, 32'h01);
        wbRead(A_PENDING, rdata); checkOutput("w1c_setWins", rdata, 32'h01);
        wbWrite(A_PENDING, 32'h01);
        wbRead(A_PENDING, rdata); checkOutput("w1c_clear", rdata, 32'h0);
        applyStimulus(8'h00, 1'b0, 3);

        // Reset while in SVC
        wbWrite(A_ENABLE, 32'h01);
        applyStimulus(8'h01, 1'b0, 1);
        applyStimulus(8'h00, 1'b0, 2 + SYNC_LAT);
        checkOutput("svc_meip", {31'b0, meip_o}, 32'h1);
        applyStimulus(8'h00, 1'b1, 1);
        wbRead(A_CLAIM, rdata);   checkOutput("svc_claim", rdata, 32'h8000_0000);
        reset_i = 1'b0;
        tick(1);
        reset_i = 1'b1;
        tick(1);
        checkOutput("svcRst_meip", {31'b0, meip_o}, 32'h0);
        wbRead(A_CLAIM, rdata);   checkOutput("svcRst_claim", rdata, 32'h0);
        wbRead(A_ENABLE, rdata);  checkOutput("svcRst_enable", rdata, 32'h0);
        wbRead(A_EDGE, rdata);    checkOutput("svcRst_edge", rdata, 32'h0);
        wbWrite(A_EDGE, 32'h01);
        wbWrite(A_ENABLE, 32'h01);
        applyStimulus(8'h00, 1'b0, 4);
        checkOutput("svcRst_quiet", {31'b0, meip_o}, 32'h0);
        applyStimulus(8'h01, 1'b0, 1);
        applyStimulus(8'h00, 1'b0, 2 + SYNC_LAT);
        checkOutput("svcRst_newEdge", {31'b0, meip_o}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
